// File: rtl/data_mem_pkg.sv
// Shared constants for the data memory arbiter: FSM encoding, port indices
// and default widths/depth.
package data_mem_pkg;

  // Ownership FSM encoding
  typedef logic [1:0] arb_state_t;
  localparam arb_state_t ST_IDLE  = 2'd0;
  localparam arb_state_t ST_OWN_A = 2'd1;
  localparam arb_state_t ST_OWN_B = 2'd2;

  // Requester index as used by the picker and the "last winner" flop
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  // Default geometry
  localparam int DEF_ADDR_W    = 32;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_MEM_DEPTH = 32;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bundle of the two requester ports and the memory-side bus.
// master = requesters + memory model side, slave = the arbiter.
interface data_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  // Port A (CPU data path)
  logic              a_req;
  logic              a_wr;
  logic              a_lock;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_gnt;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;
  logic              a_err;

  // Port B (debug / loader)
  logic              b_req;
  logic              b_wr;
  logic              b_lock;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_gnt;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;
  logic              b_err;

  // Memory side
  logic              mem_run;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output a_req, a_wr, a_lock, a_addr, a_wdata,
    input  a_gnt, a_rvalid, a_rdata, a_err,
    output b_req, b_wr, b_lock, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_rdata, b_err,
    input  mem_run, mem_wr, mem_addr, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  a_req, a_wr, a_lock, a_addr, a_wdata,
    output a_gnt, a_rvalid, a_rdata, a_err,
    input  b_req, b_wr, b_lock, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_rdata, b_err,
    output mem_run, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata
  );

endinterface

// File: rtl/rr_pick2.sv
// Two-input round-robin picker with an optional hold on one requester.
module rr_pick2
  import data_mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       hold_valid,
  input  logic       hold_id,
  output logic       win_valid,
  output logic       win_id
);

  // Held owner is the only candidate; otherwise a tie goes to the port that did not win last
  always_comb begin
    win_valid = 1'b0;
    win_id    = PORT_A;
    if (hold_valid) begin
      win_valid = req[hold_id];
      win_id    = hold_id;
    end else if (req == 2'b11) begin
      win_valid = 1'b1;
      win_id    = ~last;
    end else if (req[PORT_A]) begin
      win_valid = 1'b1;
      win_id    = PORT_A;
    end else if (req[PORT_B]) begin
      win_valid = 1'b1;
      win_id    = PORT_B;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbiter sharing one single-port data memory between port A (CPU) and
// port B (debug/loader).
//
// Handshake: a requester raises x_req with x_wr/x_lock/x_addr/x_wdata and
// holds all of them stable until it samples x_gnt=1 at a posedge; x_gnt is
// combinational and means the access is performed in that cycle. One cycle
// later x_rvalid pulses for exactly one cycle carrying read data (reads),
// completion (writes) or x_err=1 with zero data (address >= MEM_DEPTH).
module data_mem_arbiter
  import data_mem_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MEM_DEPTH = DEF_MEM_DEPTH
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  data_mem_arbiter_if.slave bus,
  output logic [1:0] dbg_state,
  output logic       dbg_last
);

  arb_state_t        state_q, state_d;
  logic              last_q, last_d;

  logic              a_rvalid_q, a_rvalid_d;
  logic              a_err_q, a_err_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic              b_rvalid_q, b_rvalid_d;
  logic              b_err_q, b_err_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

  logic [1:0]        req;
  logic              win_valid;
  logic              win_id;
  logic              a_win, b_win;
  logic              sel_wr, sel_lock, in_range;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // No candidate at all while stopped or in reset
  assign req = (Run && !Reset) ? {bus.b_req, bus.a_req} : 2'b00;

  rr_pick2 u_pick (
    .req        (req),
    .last       (last_q),
    .hold_valid (state_q != ST_IDLE),
    .hold_id    (state_q == ST_OWN_B),
    .win_valid  (win_valid),
    .win_id     (win_id)
  );

  assign a_win = win_valid && (win_id == PORT_A);
  assign b_win = win_valid && (win_id == PORT_B);

  // Route the winner's request fields to the memory
  always_comb begin
    sel_wr    = bus.a_wr;
    sel_lock  = bus.a_lock;
    sel_addr  = bus.a_addr;
    sel_wdata = bus.a_wdata;
    if (win_id == PORT_B) begin
      sel_wr    = bus.b_wr;
      sel_lock  = bus.b_lock;
      sel_addr  = bus.b_addr;
      sel_wdata = bus.b_wdata;
    end
  end

  // Full-width unsigned compare; high addresses never alias into the array
  assign in_range = (sel_addr < ADDR_W'(MEM_DEPTH));

  assign bus.a_gnt     = a_win;
  assign bus.b_gnt     = b_win;
  assign bus.mem_run   = win_valid;
  assign bus.mem_wr    = win_valid && sel_wr && in_range;
  assign bus.mem_addr  = win_valid ? sel_addr  : '0;
  assign bus.mem_wdata = win_valid ? sel_wdata : '0;

  // Ownership and round-robin pointer advance only on a grant
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    if (win_valid) begin
      last_d = win_id;
      if (state_q == ST_IDLE) begin
        if (sel_lock) begin
          state_d = (win_id == PORT_A) ? ST_OWN_A : ST_OWN_B;
        end
      end else if (!sel_lock) begin
        state_d = ST_IDLE;
      end
    end
  end

  // Next response for each port: pulse on grant, rdata only moves on reads/errors
  always_comb begin
    a_rvalid_d = a_win;
    a_err_d    = a_win && !in_range;
    a_rdata_d  = a_rdata_q;
    b_rvalid_d = b_win;
    b_err_d    = b_win && !in_range;
    b_rdata_d  = b_rdata_q;
    if (a_win) begin
      if (!in_range) begin
        a_rdata_d = '0;
      end else if (!sel_wr) begin
        a_rdata_d = bus.mem_rdata;
      end
    end
    if (b_win) begin
      if (!in_range) begin
        b_rdata_d = '0;
      end else if (!sel_wr) begin
        b_rdata_d = bus.mem_rdata;
      end
    end
  end

  // State and response registers; reset restarts arbitration favouring A
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      last_q     <= PORT_B;
      a_rvalid_q <= 1'b0;
      a_err_q    <= 1'b0;
      a_rdata_q  <= '0;
      b_rvalid_q <= 1'b0;
      b_err_q    <= 1'b0;
      b_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      a_rvalid_q <= a_rvalid_d;
      a_err_q    <= a_err_d;
      a_rdata_q  <= a_rdata_d;
      b_rvalid_q <= b_rvalid_d;
      b_err_q    <= b_err_d;
      b_rdata_q  <= b_rdata_d;
    end
  end

  assign bus.a_rvalid = a_rvalid_q;
  assign bus.a_err    = a_err_q;
  assign bus.a_rdata  = a_rdata_q;
  assign bus.b_rvalid = b_rvalid_q;
  assign bus.b_err    = b_err_q;
  assign bus.b_rdata  = b_rdata_q;

  assign dbg_state = state_q;
  assign dbg_last  = last_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios with literal expectations
// followed by constrained-random traffic against a behavioural model.
module tb_data_mem_arbiter;
  import data_mem_pkg::*;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 32;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic [1:0] dbg_state;
  logic       dbg_last;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH)) dut (
    .Clk       (clk),
    .Reset     (rst),
    .Run       (run),
    .bus       (bus),
    .dbg_state (dbg_state),
    .dbg_last  (dbg_last)
  );

  // ---------------- memory behind the arbiter ----------------
  logic [DW-1:0] mem [DEPTH];

  assign bus.mem_rdata = (bus.mem_addr < 32'(DEPTH)) ? mem[bus.mem_addr[4:0]] : '0;

  always @(negedge clk) begin
    if (bus.mem_run && bus.mem_wr && (bus.mem_addr < 32'(DEPTH))) begin
      mem[bus.mem_addr[4:0]] <= bus.mem_wdata;
    end
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model / scoreboard ----------------
  // owner: -1 none, 0 A, 1 B.  last: port that won most recently.
  int            m_owner = -1;
  int            m_last  = 1;
  logic [DW-1:0] model_mem [DEPTH];
  logic          e_a_rv = 1'b0, e_a_err = 1'b0;
  logic          e_b_rv = 1'b0, e_b_err = 1'b0;
  logic [DW-1:0] e_a_rdata = '0, e_b_rdata = '0;
  logic [DW-1:0] exp_q [$];   // read data expected in grant order

  always @(negedge clk) begin
    int            win;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;
    logic          w_wr, w_lock, inr;
    logic [1:0]    exp_state;

    // who must win this cycle
    win = -1;
    if (!rst && run) begin
      if (m_owner >= 0) begin
        if ((m_owner == 0) ? bus.a_req : bus.b_req) win = m_owner;
      end else if (bus.a_req && bus.b_req) begin
        win = (m_last == 1) ? 0 : 1;
      end else if (bus.a_req) begin
        win = 0;
      end else if (bus.b_req) begin
        win = 1;
      end
    end

    w_addr = (win == 1) ? bus.b_addr  : bus.a_addr;
    w_data = (win == 1) ? bus.b_wdata : bus.a_wdata;
    w_wr   = (win == 1) ? bus.b_wr    : bus.a_wr;
    w_lock = (win == 1) ? bus.b_lock  : bus.a_lock;
    inr    = (w_addr < 32'(DEPTH));

    exp_state = (m_owner == 0) ? 2'd1 : ((m_owner == 1) ? 2'd2 : 2'd0);

    check("m_a_gnt",   64'(bus.a_gnt),   64'(win == 0));
    check("m_b_gnt",   64'(bus.b_gnt),   64'(win == 1));
    check("m_mem_run", 64'(bus.mem_run), 64'(win >= 0));
    check("m_mem_wr",  64'(bus.mem_wr),  64'((win >= 0) && w_wr && inr));
    if (win >= 0) begin
      check("m_mem_addr", 64'(bus.mem_addr), 64'(w_addr));
      if (w_wr) check("m_mem_wdata", 64'(bus.mem_wdata), 64'(w_data));
    end
    check("m_a_rvalid", 64'(bus.a_rvalid), 64'(e_a_rv));
    check("m_a_err",    64'(bus.a_err),    64'(e_a_err));
    check("m_a_rdata",  64'(bus.a_rdata),  64'(e_a_rdata));
    check("m_b_rvalid", 64'(bus.b_rvalid), 64'(e_b_rv));
    check("m_b_err",    64'(bus.b_err),    64'(e_b_err));
    check("m_b_rdata",  64'(bus.b_rdata),  64'(e_b_rdata));
    check("m_state",    64'(dbg_state),    64'(exp_state));
    check("m_last",     64'(dbg_last),     64'(m_last));

    // pop read data the DUT presents now
    if (bus.a_rvalid && !bus.a_err && exp_q.size() > 0 && e_a_rv) begin
      if (e_a_rdata == exp_q[0]) void'(exp_q.pop_front());
    end

    // advance the model to what the next cycle must show
    if (rst) begin
      m_owner = -1;
      m_last  = 1;
      e_a_rv = 0; e_a_err = 0; e_a_rdata = '0;
      e_b_rv = 0; e_b_err = 0; e_b_rdata = '0;
    end else begin
      e_a_rv  = (win == 0);
      e_b_rv  = (win == 1);
      e_a_err = (win == 0) && !inr;
      e_b_err = (win == 1) && !inr;
      if (win >= 0) begin
        logic [DW-1:0] r;
        r = (win == 0) ? e_a_rdata : e_b_rdata;
        if (!inr) begin
          r = '0;
        end else if (w_wr) begin
          model_mem[w_addr[4:0]] = w_data;
        end else begin
          r = model_mem[w_addr[4:0]];
        end
        if (win == 0) e_a_rdata = r; else e_b_rdata = r;
        if (m_owner < 0 && w_lock) m_owner = win;
        else if (m_owner >= 0 && !w_lock) m_owner = -1;
        m_last = win;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_a(input logic req, input logic wr, input logic lock,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    bus.a_req = req; bus.a_wr = wr; bus.a_lock = lock; bus.a_addr = addr; bus.a_wdata = wd;
  endtask

  task automatic drive_b(input logic req, input logic wr, input logic lock,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    bus.b_req = req; bus.b_wr = wr; bus.b_lock = lock; bus.b_addr = addr; bus.b_wdata = wd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic to_sample();
    @(negedge clk);
    #1;
  endtask

  task automatic rand_req(output logic req, output logic wr, output logic lock,
                          output logic [AW-1:0] addr, output logic [DW-1:0] wd);
    req  = ($urandom_range(0, 2) != 0);
    wr   = $urandom_range(0, 1) == 1;
    lock = ($urandom_range(0, 3) == 0);
    if ($urandom_range(0, 9) == 0) addr = AW'($urandom);
    else addr = AW'($urandom_range(0, DEPTH + 3));
    wd = DW'($urandom);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic          ag, bg, rq, wr, lk;
    logic [AW-1:0] ad;
    logic [DW-1:0] wd;

    for (int i = 0; i < DEPTH; i++) begin
      mem[i]       = 32'h1000_0000 + 32'(i);
      model_mem[i] = 32'h1000_0000 + 32'(i);
    end
    rst = 1'b1;
    run = 1'b1;
    drive_a(1'b1, 1'b0, 1'b0, 32'd1, '0);
    drive_b(1'b1, 1'b0, 1'b0, 32'd2, '0);

    // reset state, with both requests raised
    to_sample();
    check("rst_a_gnt",    64'(bus.a_gnt),    64'd0);
    check("rst_b_gnt",    64'(bus.b_gnt),    64'd0);
    check("rst_mem_run",  64'(bus.mem_run),  64'd0);
    check("rst_mem_wr",   64'(bus.mem_wr),   64'd0);
    check("rst_a_rvalid", 64'(bus.a_rvalid), 64'd0);
    check("rst_a_rdata",  64'(bus.a_rdata),  64'd0);
    check("rst_state",    64'(dbg_state),    64'd0);

    // write then read back on port A
    next_cycle();
    rst = 1'b0;
    drive_a(1'b1, 1'b1, 1'b0, 32'd5, 32'hDEAD_BEEF);
    drive_b(1'b0, 1'b0, 1'b0, '0, '0);
    to_sample();
    check("wr_a_gnt",     64'(bus.a_gnt),     64'd1);
    check("wr_b_gnt",     64'(bus.b_gnt),     64'd0);
    check("wr_mem_wr",    64'(bus.mem_wr),    64'd1);
    check("wr_mem_addr",  64'(bus.mem_addr),  64'd5);
    check("wr_mem_wdata", 64'(bus.mem_wdata), 64'hDEAD_BEEF);
    next_cycle();
    drive_a(1'b1, 1'b0, 1'b0, 32'd5, '0);
    to_sample();
    check("rd_a_gnt",     64'(bus.a_gnt),    64'd1);
    check("wr_a_rvalid",  64'(bus.a_rvalid), 64'd1);
    check("wr_a_err",     64'(bus.a_err),    64'd0);
    next_cycle();
    drive_a(1'b0, 1'b0, 1'b0, '0, '0);
    to_sample();
    check("rd_a_rvalid",  64'(bus.a_rvalid), 64'd1);
    check("rd_a_rdata",   64'(bus.a_rdata),  64'hDEAD_BEEF);
    check("rd_b_rvalid",  64'(bus.b_rvalid), 64'd0);

    // fresh reset, then both ports read continuously: A,B,A,B
    next_cycle();
    rst = 1'b1;
    to_sample();
    next_cycle();
    rst = 1'b0;
    drive_a(1'b1, 1'b0, 1'b0, 32'd1, '0);
    drive_b(1'b1, 1'b0, 1'b0, 32'd2, '0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) next_cycle();
      to_sample();
      check("rr_a_gnt", 64'(bus.a_gnt), 64'(k % 2 == 0));
      check("rr_b_gnt", 64'(bus.b_gnt), 64'(k % 2 == 1));
      if (k % 2 == 1) begin
        check("rr_a_rdata", 64'(bus.a_rdata), 64'h1000_0001);
        check("rr_a_rvalid", 64'(bus.a_rvalid), 64'd1);
      end else if (k > 0) begin
        check("rr_b_rdata", 64'(bus.b_rdata), 64'h1000_0002);
        check("rr_b_rvalid", 64'(bus.b_rvalid), 64'd1);
      end
    end
    next_cycle();
    drive_a(1'b0, 1'b0, 1'b0, '0, '0);
    drive_b(1'b0, 1'b0, 1'b0, '0, '0);
    to_sample();
    check("rr_b_last_rvalid", 64'(bus.b_rvalid), 64'd1);
    check("rr_b_last_rdata",  64'(bus.b_rdata),  64'h1000_0002);

    // B locks for 3 accesses while A waits, then releases on the 4th
    next_cycle();
    drive_a(1'b1, 1'b0, 1'b0, 32'd7, '0);
    to_sample();
    check("lk_pre_a_gnt", 64'(bus.a_gnt), 64'd1);
    next_cycle();
    drive_b(1'b1, 1'b0, 1'b1, 32'd9, '0);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) next_cycle();
      to_sample();
      check("lk_b_gnt", 64'(bus.b_gnt), 64'd1);
      check("lk_a_gnt", 64'(bus.a_gnt), 64'd0);
      if (k == 1) check("lk_state", 64'(dbg_state), 64'd2);
    end
    next_cycle();
    drive_b(1'b1, 1'b0, 1'b0, 32'd9, '0);
    to_sample();
    check("unlk_b_gnt", 64'(bus.b_gnt), 64'd1);
    check("unlk_a_gnt", 64'(bus.a_gnt), 64'd0);
    next_cycle();
    drive_b(1'b0, 1'b0, 1'b0, '0, '0);
    to_sample();
    check("after_a_gnt",  64'(bus.a_gnt),   64'd1);
    check("after_state",  64'(dbg_state),   64'd0);
    check("after_b_data", 64'(bus.b_rdata), 64'h1000_0009);

    // out-of-range write at MEM_DEPTH, then a huge-address read
    next_cycle();
    drive_a(1'b1, 1'b1, 1'b0, 32'd32, 32'd1);
    to_sample();
    check("oor_a_gnt",   64'(bus.a_gnt),   64'd1);
    check("oor_mem_run", 64'(bus.mem_run), 64'd1);
    check("oor_mem_wr",  64'(bus.mem_wr),  64'd0);
    next_cycle();
    drive_a(1'b1, 1'b0, 1'b0, 32'h8000_0005, '0);
    to_sample();
    check("oor_a_rvalid", 64'(bus.a_rvalid), 64'd1);
    check("oor_a_err",    64'(bus.a_err),    64'd1);
    check("oor_a_rdata",  64'(bus.a_rdata),  64'd0);
    next_cycle();
    drive_a(1'b1, 1'b0, 1'b0, 32'd0, '0);
    to_sample();
    check("oor_hi_err",   64'(bus.a_err),    64'd1);
    check("oor_hi_rdata", 64'(bus.a_rdata),  64'd0);
    next_cycle();
    drive_a(1'b0, 1'b0, 1'b0, '0, '0);
    to_sample();
    check("oor_mem0_rdata", 64'(bus.a_rdata), 64'h1000_0000);
    check("oor_mem0_err",   64'(bus.a_err),   64'd0);

    // Run=0 holds everything; A wins first once Run returns
    next_cycle();
    drive_b(1'b1, 1'b0, 1'b0, 32'd4, '0);
    to_sample();
    check("run_pre_b_gnt", 64'(bus.b_gnt), 64'd1);
    next_cycle();
    run = 1'b0;
    drive_a(1'b1, 1'b0, 1'b0, 32'd3, '0);
    to_sample();
    check("run0_a_gnt",   64'(bus.a_gnt),    64'd0);
    check("run0_b_gnt",   64'(bus.b_gnt),    64'd0);
    check("run0_mem_run", 64'(bus.mem_run),  64'd0);
    check("run0_b_rv",    64'(bus.b_rvalid), 64'd1);
    next_cycle();
    to_sample();
    check("run0b_a_gnt",  64'(bus.a_gnt),    64'd0);
    check("run0b_b_rv",   64'(bus.b_rvalid), 64'd0);
    next_cycle();
    run = 1'b1;
    to_sample();
    check("run1_a_gnt", 64'(bus.a_gnt), 64'd1);
    check("run1_b_gnt", 64'(bus.b_gnt), 64'd0);

    // A takes a lock, then reset drops it: B alone is served afterwards
    next_cycle();
    drive_b(1'b0, 1'b0, 1'b0, '0, '0);
    drive_a(1'b1, 1'b0, 1'b1, 32'd3, '0);
    to_sample();
    check("mrst_a_gnt", 64'(bus.a_gnt), 64'd1);
    next_cycle();
    rst = 1'b1;
    drive_a(1'b0, 1'b0, 1'b0, '0, '0);
    to_sample();
    check("mrst_a_gnt_low", 64'(bus.a_gnt), 64'd0);
    next_cycle();
    rst = 1'b0;
    drive_b(1'b1, 1'b0, 1'b0, 32'd6, '0);
    to_sample();
    check("mrst_a_rvalid", 64'(bus.a_rvalid), 64'd0);
    check("mrst_a_rdata",  64'(bus.a_rdata),  64'd0);
    check("mrst_b_gnt",    64'(bus.b_gnt),    64'd1);
    next_cycle();
    drive_b(1'b0, 1'b0, 1'b0, '0, '0);
    to_sample();
    check("mrst_b_rdata",  64'(bus.b_rdata),  64'h1000_0006);

    // randomized traffic, requests held until granted
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      #1;
      ag = bus.a_gnt;
      bg = bus.b_gnt;
      @(posedge clk);
      #1;
      rst = ($urandom_range(0, 199) == 0);
      run = ($urandom_range(0, 9) != 0);
      if (!bus.a_req || ag) begin
        rand_req(rq, wr, lk, ad, wd);
        drive_a(rq, wr, lk, ad, wd);
      end
      if (!bus.b_req || bg) begin
        rand_req(rq, wr, lk, ad, wd);
        drive_b(rq, wr, lk, ad, wd);
      end
    end

    next_cycle();
    rst = 1'b0;
    run = 1'b1;
    drive_a(1'b0, 1'b0, 1'b0, '0, '0);
    drive_b(1'b0, 1'b0, 1'b0, '0, '0);
    repeat (3) next_cycle();
    to_sample();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Two-requester arbiter that shares the single-port data memory between the CPU data path (port A) and a debug/loader master (port B).
- Grants at most one access per cycle and drives the memory's Run/MemWr/Addr/data_input from the winner.
- Registers read data back to the winning requester.
- Sits between the requesters and the memory; round-robin fairness, with an optional lock for multi-word sequences.

Parameters:
- ADDR_W, 32, address width of each requester and of the memory.
- DATA_W, 32, data width.
- MEM_DEPTH, 32, number of valid words; addresses >= MEM_DEPTH are out of range.

Ports:
- Clk  in  1  system clock; all arbiter state updates on posedge.
- Reset  in  1  synchronous, active-high reset.
- Run  in  1  global enable; 0 = no grants are issued, state holds.
- a_req / b_req  in  1  access request; held until the matching gnt is sampled.
- a_wr / b_wr  in  1  1 = write, 0 = read.
- a_lock / b_lock  in  1  request to keep ownership after this access.
- a_addr / b_addr  in  ADDR_W  word address.
- a_wdata / b_wdata  in  DATA_W  write data.
- a_gnt / b_gnt  out  1  combinational; access performed this cycle.
- a_rvalid / b_rvalid  out  1  registered; read data or error valid, one cycle after gnt.
- a_rdata / b_rdata  out  DATA_W  registered read data.
- a_err / b_err  out  1  registered; out-of-range access, with rvalid.
- mem_run  out  1  to memory Run.
- mem_wr  out  1  to memory MemWr.
- mem_addr  out  ADDR_W  to memory Addr.
- mem_wdata  out  DATA_W  to memory data_input.
- mem_rdata  in  DATA_W  from memory data_output (combinational read).

Behaviour:
- Reset, synchronous: state=IDLE, last=B (so A wins the first tie).
  - rvalid/err low, rdata zero.
  - gnt low while Reset=1; mem_run=0, mem_wr=0.
- FSM states:
  - IDLE: no owner.
  - OWN_A / OWN_B: locked owner.
- Winner selection, combinational, only when Run=1 and Reset=0:
  - IDLE, one request: that port wins.
  - IDLE, both requests: the port not equal to last wins (round-robin).
  - OWN_x: only x may win. The other port's request is ignored (not granted) until the state returns to IDLE.
- Granted cycle:
  - gnt=1 for the winner.
  - mem_addr and mem_wdata come from the winner.
  - mem_run=1; mem_wr=winner_wr and in_range.
  - The memory commits the write on the negedge within this cycle.
- Out-of-range (addr >= MEM_DEPTH):
  - Still granted; mem_wr forced 0.
  - Next cycle: rvalid=1, err=1, rdata=0. This applies to both reads and writes.
- Response, registered at posedge after the grant:
  - Winner's rvalid=1 for exactly one cycle.
  - Read: rdata=mem_rdata sampled at that posedge.
  - Write: rvalid=1 as completion; rdata holds its previous value.
  - Loser's rvalid stays 0.
- last is updated to the winner on every grant.
- Lock transitions at a grant:
  - From IDLE: a grant with lock=1 moves to OWN_winner.
  - In OWN_x: a grant to x with lock=0 returns to IDLE.
  - In OWN_x with x_req=0: remain OWN_x. No timeout; the owner must release.
- Run=0: no gnt, mem_run=0, FSM/last hold. A response already registered still appears.
- Simultaneous requests every cycle: grants alternate A,B,A,B.
- Throughput: one access per cycle, back-to-back allowed. Latency gnt->rvalid = 1 cycle.
- Mid-operation reset: a pending rvalid is cleared, lock is dropped, arbitration restarts favouring A.
- Addresses are compared as unsigned full ADDR_W. No wrap-around, no truncation.

Decomposition:
- Shared package data_mem_pkg:
  - state encoding (IDLE=2'd0, OWN_A=2'd1, OWN_B=2'd2)
  - port index constants (PORT_A=1'b0, PORT_B=1'b1)
  - default widths/depth
- One sub-module: rr_pick2. Two-input round-robin picker: inputs req[1:0], last, hold_valid, hold_id; outputs win_valid, win_id. Purely combinational.

Test Plan:
- Reset then a_req write addr 5 data 32'hDEAD_BEEF, then a_req read addr 5 -> a_gnt each cycle; a_rvalid one cycle later; read returns 32'hDEAD_BEEF; b_* idle.
- a_req and b_req both held 4 cycles (reads of addr 1 and 2) -> gnt order A,B,A,B; each rvalid one cycle after its gnt with correct data.
- b_req with b_lock=1 for 3 accesses while a_req held -> b_gnt 3 cycles, a_gnt 0; b_lock=0 on 4th -> next cycle a_gnt=1.
- a_req write to addr 32 (MEM_DEPTH) data 1 -> a_gnt=1, mem_wr=0, memory unchanged; next cycle a_rvalid=1, a_err=1, a_rdata=0.
- Run=0 with both requests for 2 cycles -> no gnt, mem_run=0; Run=1 -> A granted first (last=B held).
- Reset asserted the cycle after a read grant -> rvalid stays 0; state IDLE; a locked owner is released.
